// File: rtl/seqdet_stream_ctrl_if.sv
// Word-side bundle of the sequence-detector stream controller: valid/ready word input, threshold/clear controls, detection outputs.
// No latency of its own; backpressure is carried by in_ready, driven by the slave side.
interface seqdet_stream_ctrl_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [CNT_W-1:0] thresh;
    logic             clr;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic             irq;
    logic             busy;

    modport master (
        output in_valid, in_data, thresh, clr,
        input  in_ready, hit, hit_cnt, irq, busy
    );

    modport slave (
        input  in_valid, in_data, thresh, clr,
        output in_ready, hit, hit_cnt, irq, busy
    );
endinterface

// File: rtl/seqdet_stream_ctrl.sv
// Serializes valid/ready words MSB-first into a 1010 detector with a saturating hit counter and sticky irq; define SEQDET_CTRL_OVERLAP_EN for overlapping matches.
// Latency: hit/hit_cnt/irq one cycle after the matching bit; backpressure: in_ready only in IDLE or on the last bit of a word.
module seqdet_stream_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seqdet_stream_ctrl_if.slave  bus
);
    localparam int               BW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0]    LAST    = BW'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_SHIFT} ctrl_e;
    typedef enum logic [2:0] {D_A, D_B, D_C, D_D, D_E} det_e;

    ctrl_e            state_q, state_d;
    det_e             det_q, det_d;
    logic [W-1:0]     sreg_q, sreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             irq_q, irq_d;

    logic             in_ready;
    logic             busy;
    logic             bit_vld;
    logic             bit_in;
    logic             det_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign bit_in = sreg_q[W-1];

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        bit_vld   = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    sreg_d    = bus.in_data;
                    bit_cnt_d = LAST;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy      = 1'b1;
                bit_vld   = 1'b1;
                sreg_d    = {sreg_q[W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
                // Last bit: a reload here keeps the stream gap-free.
                if (bit_cnt_q == '0) begin
                    in_ready  = 1'b1;
                    bit_cnt_d = '0;
                    if (bus.in_valid) begin
                        sreg_d    = bus.in_data;
                        bit_cnt_d = LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        det_d   = det_q;
        det_hit = 1'b0;
        if (bit_vld) begin
            case (det_q)
                D_A: det_d = bit_in ? D_B : D_A;
                D_B: det_d = bit_in ? D_B : D_C;
                D_C: det_d = bit_in ? D_D : D_A;
                D_D: begin
                    if (bit_in) begin
                        det_d = D_B;
                    end else begin
                        det_hit = 1'b1;
`ifdef SEQDET_CTRL_OVERLAP_EN
                        det_d   = D_E;
`else
                        det_d   = D_A;
`endif
                    end
                end
                D_E:     det_d = bit_in ? D_D : D_A;
                default: det_d = D_A;
            endcase
        end
    end

    assign cnt_inc = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + 1'b1;

    always_comb begin
        hit_d     = det_hit;
        hit_cnt_d = hit_cnt_q;
        irq_d     = irq_q;
        // Clear wins over a coincident detection, but the hit pulse still fires.
        if (bus.clr) begin
            hit_cnt_d = '0;
            irq_d     = 1'b0;
        end else if (det_hit) begin
            hit_cnt_d = cnt_inc;
            if ((bus.thresh != '0) && (cnt_inc == bus.thresh)) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            det_q     <= D_A;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            det_q     <= det_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.hit      = hit_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.irq      = irq_q;
endmodule
